// File: rtl/modulo_seq_ctrl.sv
// Run-control sequencer for a modulo-N counter: clears it, gates its ce,
// counts wrap-arounds and ends one-shot runs after a programmed period count.
module modulo_seq_ctrl #(
  parameter int N     = 10,
  parameter int WIDTH = $clog2(N),
  parameter int REPW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [REPW-1:0]  reps,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             ce,
  output logic             cnt_clr,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [REPW-1:0]  wrap_cnt
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [REPW-1:0] wrap_cnt_reg;
  logic [REPW-1:0] reps_reg;
  logic            mode_reg;
  logic            tick_reg;

  logic wrap_evt;
  logic last_wrap;
  logic launch;

  // A stop in the same cycle suppresses the wrap so wrap_cnt and tick hold.
  assign wrap_evt  = (state_reg == RUN) && !pause && !stop &&
                     (cnt_in == WIDTH'(N - 1));
  // reps of zero wraps to all-ones here, giving a full 2^REPW periods.
  assign last_wrap = (wrap_cnt_reg == reps_reg - REPW'(1));
  assign launch    = start && ((state_reg == IDLE) || (state_reg == DONE));

  always_comb begin
    state_next = state_reg;
    ce         = 1'b0;
    cnt_clr    = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = CLEAR;
      end
      CLEAR: begin
        cnt_clr    = 1'b1;
        busy       = 1'b1;
        state_next = stop ? IDLE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        ce   = !pause;
        if (stop)
          state_next = IDLE;
        else if (wrap_evt && !mode_reg && last_wrap)
          state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = start ? CLEAR : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      wrap_cnt_reg <= '0;
      reps_reg     <= '0;
      mode_reg     <= 1'b0;
      tick_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      tick_reg  <= wrap_evt;
      if (launch) begin
        reps_reg     <= reps;
        mode_reg     <= mode;
        wrap_cnt_reg <= '0;
      end else if (wrap_evt) begin
        wrap_cnt_reg <= wrap_cnt_reg + REPW'(1);
      end
    end
  end

  assign tick     = tick_reg;
  assign wrap_cnt = wrap_cnt_reg;

endmodule

// File: tb/tb_modulo_seq_ctrl.sv
// Directed bench for modulo_seq_ctrl driving a behavioural modulo-10 counter
// with a 2-bit repetition width.
module tb_modulo_seq_ctrl;

  localparam int N     = 10;
  localparam int WIDTH = 4;
  localparam int REPW  = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, stop, pause, mode;
  logic [REPW-1:0]  reps;
  logic [WIDTH-1:0] cnt_in;
  logic             ce, cnt_clr, busy, tick, done;
  logic [REPW-1:0]  wrap_cnt;

  int vectors = 0;
  int miscompares = 0;
  int ce_seen, tick_seen, done_seen, done_at, done_first, done_second, n;
  logic [REPW-1:0] seq [8];

  always #5 clk = ~clk;

  modulo_seq_ctrl #(.N(N), .WIDTH(WIDTH), .REPW(REPW)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .reps(reps), .cnt_in(cnt_in), .ce(ce), .cnt_clr(cnt_clr),
    .busy(busy), .tick(tick), .done(done), .wrap_cnt(wrap_cnt)
  );

  // Controlled modulo-10 counter
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) cnt_in <= '0;
    else if (ce)        cnt_in <= (cnt_in == 4'd9) ? 4'd0 : cnt_in + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (ce === 1'b1)   ce_seen++;
    if (tick === 1'b1) tick_seen++;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic start_run(input logic m, input logic [REPW-1:0] r);
    start = 1'b1; mode = m; reps = r;
    step();
    start = 1'b0; mode = 1'b0; reps = '0;
    ce_seen = 0; tick_seen = 0; done_seen = 0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; stop = 1'b0; pause = 1'b0; mode = 1'b0; reps = '0;
    ce_seen = 0; tick_seen = 0; done_seen = 0;

    // Reset dominates start
    repeat (3) step();
    chk("rst_ce",       32'(ce),       32'd0);
    chk("rst_cnt_clr",  32'(cnt_clr),  32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_tick",     32'(tick),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_wrap_cnt", 32'(wrap_cnt), 32'd0);
    start = 1'b0; rst = 1'b0;
    repeat (3) step();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_clr",  32'(cnt_clr), 32'd0);

    // One-shot, reps=2
    start_run(1'b0, 2'd2);
    chk("os_clr",      32'(cnt_clr), 32'd1);
    chk("os_clr_busy", 32'(busy),    32'd1);
    chk("os_clr_ce",   32'(ce),      32'd0);
    step();
    chk("os_run_ce", 32'(ce),     32'd1);
    chk("os_cnt0",   32'(cnt_in), 32'd0);
    repeat (10) step();
    chk("os_tick1",  32'(tick),     32'd1);
    chk("os_wrap1",  32'(wrap_cnt), 32'd1);
    step();
    chk("os_tick1_end", 32'(tick), 32'd0);
    repeat (9) step();
    chk("os_done",      32'(done),     32'd1);
    chk("os_tick2",     32'(tick),     32'd1);
    chk("os_wrap2",     32'(wrap_cnt), 32'd2);
    chk("os_done_busy", 32'(busy),     32'd0);
    chk("os_done_cnt",  32'(cnt_in),   32'd0);
    chk("os_ce_cycles", 32'(ce_seen),  32'd20);
    step();
    chk("os_done_end", 32'(done),     32'd0);
    chk("os_idle",     32'(busy),     32'd0);
    chk("os_hold",     32'(wrap_cnt), 32'd2);

    // One-shot reps=1 with a 5-cycle pause
    start_run(1'b0, 2'd1);
    done_at = 0;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      if (k == 4) pause = 1'b1;
      if (k == 9) pause = 1'b0;
      step();
      if (k == 6) begin
        chk("pause_ce",  32'(ce),     32'd0);
        chk("pause_cnt", 32'(cnt_in), 32'd2);
      end
      if (done === 1'b1) done_at = k;
    end
    chk("pause_done_at", 32'(done_at),  32'd16);
    chk("pause_ce_cyc",  32'(ce_seen),  32'd10);
    chk("pause_wrap",    32'(wrap_cnt), 32'd1);
    step();

    // Periodic, stop at cnt_in=4 in second period
    start_run(1'b1, 2'd0);
    repeat (15) step();
    chk("stop_pre_cnt",  32'(cnt_in),   32'd4);
    chk("stop_pre_wrap", 32'(wrap_cnt), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("stop_busy", 32'(busy),     32'd0);
    chk("stop_ce",   32'(ce),       32'd0);
    chk("stop_done", 32'(done_seen), 32'd0);
    chk("stop_tick", 32'(tick),     32'd0);
    chk("stop_wrap", 32'(wrap_cnt), 32'd1);
    step();
    chk("stop_idle", 32'(busy), 32'd0);

    // Periodic, 5 periods with 2-bit wrap counter
    start_run(1'b1, 2'd1);
    n = 0;
    for (int k = 1; k <= 52; k++) begin
      step();
      if (tick === 1'b1 && n < 8) begin
        seq[n] = wrap_cnt;
        n++;
      end
    end
    chk("per_ticks", 32'(tick_seen), 32'd5);
    chk("per_done",  32'(done_seen), 32'd0);
    chk("per_seq0",  32'(seq[0]), 32'd1);
    chk("per_seq1",  32'(seq[1]), 32'd2);
    chk("per_seq2",  32'(seq[2]), 32'd3);
    chk("per_seq3",  32'(seq[3]), 32'd0);
    chk("per_seq4",  32'(seq[4]), 32'd1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("per_stop_busy", 32'(busy), 32'd0);

    // Back-to-back one-shot runs, start held through DONE
    start = 1'b1; mode = 1'b0; reps = 2'd1;
    step();
    ce_seen = 0; done_first = 0; done_second = 0;
    for (int k = 1; k <= 24; k++) begin
      if (k == 13) start = 1'b0;
      step();
      if (k == 12) chk("b2b_reclear", 32'(cnt_clr), 32'd1);
      if (done === 1'b1) begin
        if (done_first == 0) done_first = k;
        else done_second = k;
      end
    end
    chk("b2b_done1",  32'(done_first),  32'd11);
    chk("b2b_done2",  32'(done_second), 32'd23);
    chk("b2b_ce_cyc", 32'(ce_seen),     32'd20);
    chk("b2b_idle",   32'(busy),        32'd0);

    // reps=0 means 2^REPW = 4 periods
    start_run(1'b0, 2'd0);
    done_at = 0;
    for (int k = 1; k <= 60 && done_at == 0; k++) begin
      step();
      if (done === 1'b1) done_at = k;
    end
    chk("r0_done_at", 32'(done_at),   32'd41);
    chk("r0_ce_cyc",  32'(ce_seen),   32'd40);
    chk("r0_ticks",   32'(tick_seen), 32'd4);
    chk("r0_wrap",    32'(wrap_cnt),  32'd0);
    step();

    // Asynchronous reset mid-run
    start_run(1'b1, 2'd0);
    repeat (12) step();
    chk("arst_pre_wrap", 32'(wrap_cnt), 32'd1);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy),     32'd0);
    chk("arst_ce",   32'(ce),       32'd0);
    chk("arst_wrap", 32'(wrap_cnt), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("arst_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/modulo_seq_ctrl.md
Name: modulo_seq_ctrl

Overview:
Run-control sequencer for a modulo_N counter: clears it, gates its ce, counts its wrap-arounds and ends a run after a programmed number of full periods. Sits between control logic (buttons/CPU regs) and one modulo_N instance. Counter value is fed back so wraps are detected without modifying the counter. Supports one-shot and free-running (periodic) modes plus pause/stop.

Parameters:
N, 10, modulus of the controlled counter (>=2)
WIDTH, $clog2(N), width of counter value bus
REPW, 8, width of repetition count / wrap counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  begin a run (sampled in IDLE/DONE only)
stop  in  1  abort run, return to IDLE
pause  in  1  level; while high in RUN, ce held low
mode  in  1  0 = one-shot, 1 = periodic
reps  in  REPW  periods per one-shot run; 0 means 2^REPW
cnt_in  in  WIDTH  current value of controlled counter (its out)
ce  out  1  counter enable to modulo_N
cnt_clr  out  1  counter clear to modulo_N rst
busy  out  1  high in CLEAR or RUN
tick  out  1  registered 1-cycle pulse after each wrap
done  out  1  1-cycle pulse at end of one-shot run
wrap_cnt  out  REPW  wraps completed in current run

Behaviour:
- Reset (async, rst=1): state IDLE; ce=0, cnt_clr=0, busy=0, tick=0, done=0, wrap_cnt=0, latched reps/mode=0.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE: start=1 -> CLEAR; latch reps, mode; wrap_cnt<=0. Otherwise stay.
- CLEAR (1 cycle): cnt_clr=1, ce=0 -> RUN unconditionally (unless stop).
- RUN: ce = ~pause (combinational from state and pause). wrap event = RUN & ~pause & (cnt_in==N-1); at that edge wrap_cnt<=wrap_cnt+1 (mod 2^REPW) and tick<=1 next cycle.
- One-shot: wrap event with wrap_cnt==reps_latched-1 (reps 0 -> compare to 2^REPW-1) -> DONE. Periodic: never enters DONE; wrap_cnt rolls over silently.
- DONE (1 cycle): done=1, ce=0, busy=0; start=1 here -> CLEAR directly (back-to-back runs), else -> IDLE. wrap_cnt holds final value until next start.
- stop=1 in CLEAR/RUN -> IDLE next edge, no done, no tick for that cycle; wrap_cnt holds. Priority in RUN: stop > completion > pause.
- pause during final wrap cycle: no wrap event (ce=0), completion deferred.
- start while CLEAR/RUN ignored; reps/mode changes mid-run ignored (latched).
- cnt_clr, done, busy are decoded from state (glitch-free Moore outputs); tick registered.
- rst asserted mid-run: immediate return to reset values; counter is not cleared by this block (its own rst path covers it).

Test Plan:
- Reset: rst=1 with start=1 -> all outputs 0, state IDLE; release rst, no activity without start.
- One-shot N=10, reps=2, start at edge E0 -> cnt_clr=1 for cycle E0-E1; ce=1 for exactly 20 cycles (E1..E21); tick pulses after E11 and E21; done=1 for cycle E21-E22; wrap_cnt=2; cnt_in=0 at end.
- Pause: one-shot reps=1, pause=1 for 5 cycles mid-run -> ce low 5 cycles, done delayed by exactly 5 cycles, cnt_in frozen during pause.
- Stop: periodic, stop asserted with cnt_in=4 -> IDLE next cycle, ce=0, no done, wrap_cnt unchanged.
- Periodic, REPW=2, 5 periods -> tick 5 times, wrap_cnt sequence 1,2,3,0,1, done never asserted.
- Back-to-back: start held high through DONE with reps=1 -> DONE followed immediately by CLEAR, second run completes with done after another 10 ce cycles; reps=0 with REPW=2 -> done after 4 periods (40 ce cycles).
